// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative mult/div unit with HI/LO,
// and the EX/MEM pipeline register feeding the MEM stage.
module ex_stage #(
   parameter int DATA_W    = 32,
   parameter int MD_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] IDtoEX_PC,
   input  logic [DATA_W-1:0] IDtoEX_ReadData1,
   input  logic [DATA_W-1:0] IDtoEX_ReadData2,
   input  logic [DATA_W-1:0] IDtoEX_Imm,
   input  logic [4:0]        IDtoEX_Rt,
   input  logic [4:0]        IDtoEX_Rd,
   input  logic [5:0]        funct,
   input  logic [1:0]        ALUop,
   input  logic              ALUSrc,
   input  logic              RegDst,
   input  logic              Branch,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              RegWrite,
   input  logic              MemtoReg,
   input  logic [1:0]        ForwardA,
   input  logic [1:0]        ForwardB,
   input  logic [DATA_W-1:0] WB_Result,
   output logic [DATA_W-1:0] EXtoMEM_ALUresult,
   output logic [DATA_W-1:0] EXtoMEM_WriteData,
   output logic [4:0]        EXtoMEM_WriteReg,
   output logic [DATA_W-1:0] EXtoMEM_BranchTarget,
   output logic              EXtoMEM_Zero,
   output logic              EXtoMEM_Branch,
   output logic              EXtoMEM_MemRead,
   output logic              EXtoMEM_MemWrite,
   output logic              EXtoMEM_RegWrite,
   output logic              EXtoMEM_MemtoReg,
   output logic              ex_stall,
   output logic              md_busy
);

   localparam int CW = $clog2(MD_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t state, next_state;

   logic [DATA_W-1:0] op_a, rt_val, op_b, alu_result;
   logic              is_rtype, is_md, is_hilo, md_start, md_done;
   logic [DATA_W-1:0] hi_reg, lo_reg;
   logic [DATA_W-1:0] acc_hi, acc_lo, opnd, dividend;
   logic              md_div, neg_q, neg_r, dbz;
   logic [CW-1:0]     count;

   logic [DATA_W:0]   mul_sum, div_shift, div_diff;
   logic              div_ge;
   logic [DATA_W-1:0] step_hi, step_lo, fin_hi, fin_lo;
   logic [2*DATA_W-1:0] prod;

   logic              a_neg, b_neg;
   logic [DATA_W-1:0] mag_a, mag_b;

   // Forwarding muxes; setting 11 falls back to the register file value
   always_comb begin
      case (ForwardA)
         2'b10:   op_a = EXtoMEM_ALUresult;
         2'b01:   op_a = WB_Result;
         default: op_a = IDtoEX_ReadData1;
      endcase
      case (ForwardB)
         2'b10:   rt_val = EXtoMEM_ALUresult;
         2'b01:   rt_val = WB_Result;
         default: rt_val = IDtoEX_ReadData2;
      endcase
      op_b = ALUSrc ? IDtoEX_Imm : rt_val;
   end

   // Instruction class decode and the structural-hazard stall
   always_comb begin
      is_rtype = (ALUop == 2'b10);
      is_md    = is_rtype && (funct[5:2] == 4'b0110);
      is_hilo  = is_rtype && ((funct == 6'h10) || (funct == 6'h12));
      md_busy  = (state == BUSY);
      ex_stall = md_busy && (is_md || is_hilo);
      md_start = (state == IDLE) && is_md;
      md_done  = (state == BUSY) && (count == LAST);
   end

   // ALU: fixed ops from ALUop, R-type ops decoded from funct
   always_comb begin
      alu_result = '0;
      case (ALUop)
         2'b00: alu_result = op_a + op_b;
         2'b01: alu_result = op_a - op_b;
         2'b11: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         default: begin
            case (funct)
               6'h20, 6'h21: alu_result = op_a + op_b;
               6'h22, 6'h23: alu_result = op_a - op_b;
               6'h24: alu_result = op_a & op_b;
               6'h25: alu_result = op_a | op_b;
               6'h26: alu_result = op_a ^ op_b;
               6'h27: alu_result = ~(op_a | op_b);
               6'h2A: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
               6'h2B: alu_result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
               6'h00: alu_result = rt_val << IDtoEX_Imm[10:6];
               6'h02: alu_result = rt_val >> IDtoEX_Imm[10:6];
               6'h03: alu_result = DATA_W'($signed(rt_val) >>> IDtoEX_Imm[10:6]);
               6'h10: alu_result = hi_reg;
               6'h12: alu_result = lo_reg;
               default: alu_result = '0;
            endcase
         end
      endcase
   end

   // One multiply or restoring-divide iteration plus final sign correction
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
      div_shift = {acc_hi, acc_lo[DATA_W-1]};
      div_diff  = div_shift - {1'b0, opnd};
      div_ge    = (div_shift >= {1'b0, opnd});
      if (md_div) begin
         step_hi = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
         step_lo = {acc_lo[DATA_W-2:0], div_ge};
      end else begin
         step_hi = mul_sum[DATA_W:1];
         step_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
      end
      prod = {step_hi, step_lo};
      if (!md_div) begin
         prod = neg_q ? -prod : prod;
         fin_hi = prod[2*DATA_W-1:DATA_W];
         fin_lo = prod[DATA_W-1:0];
      end else if (dbz) begin
         fin_hi = dividend;
         fin_lo = '1;
      end else begin
         fin_hi = neg_r ? -step_hi : step_hi;
         fin_lo = neg_q ? -step_lo : step_lo;
      end
   end

   // Operand magnitudes for signed ops (funct bit 0 clear means signed)
   always_comb begin
      a_neg = ~funct[0] & op_a[DATA_W-1];
      b_neg = ~funct[0] & rt_val[DATA_W-1];
      mag_a = a_neg ? -op_a : op_a;
      mag_b = b_neg ? -rt_val : rt_val;
   end

   // Mult/div FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Mult/div FSM next state
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (md_start) next_state = BUSY;
         BUSY: if (count == LAST) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Mult/div datapath: latch operands, iterate, commit HI/LO on the last step
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_hi <= '0; acc_lo <= '0; opnd <= '0; dividend <= '0;
         md_div <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0; dbz <= 1'b0;
         count <= '0; hi_reg <= '0; lo_reg <= '0;
      end else if (md_start) begin
         acc_hi   <= '0;
         acc_lo   <= mag_a;
         opnd     <= mag_b;
         dividend <= op_a;
         md_div   <= funct[1];
         neg_q    <= a_neg ^ b_neg;
         neg_r    <= a_neg;
         dbz      <= (rt_val == '0);
         count    <= '0;
      end else if (state == BUSY) begin
         acc_hi <= step_hi;
         acc_lo <= step_lo;
         if (md_done) begin
            count  <= '0;
            hi_reg <= fin_hi;
            lo_reg <= fin_lo;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   // EX/MEM pipeline register; a stall inserts a bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || ex_stall) begin
         EXtoMEM_ALUresult    <= '0;
         EXtoMEM_WriteData    <= '0;
         EXtoMEM_WriteReg     <= '0;
         EXtoMEM_BranchTarget <= '0;
         EXtoMEM_Zero         <= 1'b0;
         EXtoMEM_Branch       <= 1'b0;
         EXtoMEM_MemRead      <= 1'b0;
         EXtoMEM_MemWrite     <= 1'b0;
         EXtoMEM_RegWrite     <= 1'b0;
         EXtoMEM_MemtoReg     <= 1'b0;
      end else begin
         EXtoMEM_ALUresult    <= alu_result;
         EXtoMEM_WriteData    <= rt_val;
         EXtoMEM_WriteReg     <= RegDst ? IDtoEX_Rd : IDtoEX_Rt;
         EXtoMEM_BranchTarget <= IDtoEX_PC + {IDtoEX_Imm[DATA_W-3:0], 2'b00};
         EXtoMEM_Zero         <= (alu_result == '0);
         EXtoMEM_Branch       <= Branch & ~is_md;
         EXtoMEM_MemRead      <= MemRead & ~is_md;
         EXtoMEM_MemWrite     <= MemWrite & ~is_md;
         EXtoMEM_RegWrite     <= RegWrite & ~is_md;
         EXtoMEM_MemtoReg     <= MemtoReg;
      end
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of the ID/EX pipeline register and contains the operand forwarding muxes, the ALU, and an iterative 32-cycle multiply/divide unit with HI/LO registers. It also contains the EX/MEM pipeline register that feeds the MEM stage. It raises a stall when a HI/LO consumer or a second mult/div reaches EX while the unit is busy.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
MD_CYCLES, 32, iterations per mult/div operation.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
IDtoEX_PC  in  32  PC+4 of the instruction in EX
IDtoEX_ReadData1  in  32  rs value from the register file
IDtoEX_ReadData2  in  32  rt value from the register file
IDtoEX_Imm  in  32  sign-extended immediate; [10:6] is shamt
IDtoEX_Rt  in  5  rt field
IDtoEX_Rd  in  5  rd field
funct  in  6  R-type function code
ALUop  in  2  00 add, 01 sub, 10 R-type (decode funct), 11 slt
ALUSrc, RegDst, Branch, MemRead, MemWrite, RegWrite, MemtoReg  in  1 each  control bits from ID/EX
ForwardA, ForwardB  in  2 each  00 register file, 10 EX/MEM result, 01 WB result, 11 treated as 00
WB_Result  in  32  write-back value for forwarding
EXtoMEM_ALUresult  out  32  registered ALU/HI/LO result
EXtoMEM_WriteData  out  32  registered store data (forwarded B)
EXtoMEM_WriteReg  out  5  registered destination register
EXtoMEM_BranchTarget  out  32  registered PC+4 + (Imm<<2)
EXtoMEM_Zero  out  1  registered ALU-result==0
EXtoMEM_Branch, EXtoMEM_MemRead, EXtoMEM_MemWrite, EXtoMEM_RegWrite, EXtoMEM_MemtoReg  out  1 each  registered control
ex_stall  out  1  combinational; holds PC, IF/ID and ID/EX
md_busy  out  1  mult/div unit is iterating

Behaviour:
- Reset (rst=0, asynchronous): every registered output is 0, HI=LO=0, FSM=IDLE, iteration count=0, md_busy=0, ex_stall=0. Asserting reset during an operation aborts it with no HI/LO update.
- Operand A: selected by ForwardA. The 10 setting uses this block's own EXtoMEM_ALUresult.
- Operand B: the forwarded rt value when ALUSrc=0, IDtoEX_Imm when ALUSrc=1. EXtoMEM_WriteData always takes the forwarded rt value.
- R-type funct decode:
  - 20/21 add/addu, wrap-around, no overflow trap
  - 22/23 sub/subu
  - 24 and, 25 or, 26 xor, 27 nor
  - 2A slt (signed), 2B sltu (unsigned)
  - 00 sll, 02 srl, 03 sra: rt shifted by Imm[10:6]
  - 10 mfhi, 12 mflo: result is HI/LO
  - 18 mult, 19 multu, 1A div, 1B divu: start the unit
  - any other funct: result 0
- Destination: EXtoMEM_WriteReg = RegDst ? Rd : Rt. Zero = (result==0).
- Latency: one cycle. EX/MEM captures on every edge where ex_stall=0.
- Mult/div FSM, IDLE → BUSY → IDLE:
  - In IDLE with a mult/div in EX: operands are latched and count=0.
  - Signed ops convert operands to magnitudes and record the result sign.
  - Each BUSY edge performs one shift-add multiply or restoring-divide step and count++.
  - On the edge where count==MD_CYCLES-1, sign correction is applied, HI/LO are written and the FSM returns to IDLE. md_busy is therefore high for exactly 32 cycles.
  - The mult/div instruction itself enters EX/MEM with RegWrite=MemRead=MemWrite=Branch=0.
- Multiply result: {HI,LO} = 64-bit product.
- Divide result: LO=quotient, HI=remainder. Signed division truncates toward zero and the remainder takes the dividend's sign.
  - Divide by zero: LO=FFFFFFFF, HI=dividend.
  - 80000000 / FFFFFFFF (signed): LO=80000000, HI=0.
- Stall: ex_stall = md_busy AND (EX instruction is mfhi, mflo or mult/div), decoded only when ALUop=10. While stalled:
  - EX/MEM loads a bubble: all control outputs 0, data fields don't-care but driven 0.
  - ID/EX inputs are held stable upstream.
- On the edge that completes the operation, a waiting mfhi/mflo still loads a bubble. On the next edge it reads the new HI/LO. A waiting mult/div starts on that next edge.

Test Plan:
- Reset mid-divide: start divu, drop rst after 10 cycles → all outputs 0, md_busy=0, HI=LO=0; a following mfhi returns 0.
- Forwarding: previous result 0x10 in EX/MEM, ForwardA=10, rt=3, ALUop=10, funct=20 → EXtoMEM_ALUresult=0x13. ForwardB=01 with WB_Result=7 and funct=22 → 0x10-7=9.
- Branch: ReadData1=ReadData2=7, ALUop=01, Imm=FFFFFFFE, PC=0x100 → Zero=1, BranchTarget=0xF8, Branch propagated.
- mult -3×5, mflo issued the next cycle → ex_stall high 32 cycles, EX/MEM holds bubbles; the edge after that gives EXtoMEM_ALUresult=FFFFFFF1; a subsequent mfhi → FFFFFFFF.
- Division results:
  - divu 100/7 → LO=14, HI=2
  - div -7/2 → LO=FFFFFFFD, HI=FFFFFFFF
  - div 5/0 → LO=FFFFFFFF, HI=5
- Back-to-back multu while busy: second stalls 32 cycles with RegWrite=MemWrite=0 in EX/MEM, then starts; final HI/LO equal the second product.
